mem_bus_arbiter: RTL and testbench

//  Shares the core's single SRAM-like memory bus between the IF fetch port and the MEM data port.
//  One outstanding transaction at a time; data port has priority, with anti-starvation alternation.

---
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory bus between the instruction-fetch port and the data port.
// One transaction in flight at a time; data has priority except right after a data access.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_ready,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_ready,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  stall_req
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic OWN_DATA = 1'b0;
    localparam logic OWN_INST = 1'b1;

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic       owner_r;
    logic       last_owner_r;
    logic       discard_r;
    logic       inst_live_s;
    logic       grant_s;
    logic       grant_inst_s;
    logic       inst_flush_s;
    logic       discard_eff_s;

    // Grant arbitration in IDLE and flush qualification of the current owner
    always_comb begin
        inst_live_s   = inst_req & ~flush;
        grant_s       = 1'b0;
        grant_inst_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (inst_live_s && data_req) begin
                grant_s      = 1'b1;
                // alternate after a data access so fetch cannot starve
                grant_inst_s = (last_owner_r == OWN_DATA);
            end else if (inst_live_s) begin
                grant_s      = 1'b1;
                grant_inst_s = 1'b1;
            end else if (data_req) begin
                grant_s      = 1'b1;
                grant_inst_s = 1'b0;
            end else begin
                grant_s      = 1'b0;
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_s      = 1'b0;
            grant_inst_s = 1'b0;
        end
        inst_flush_s  = (owner_r == OWN_INST) & flush;
        // a flush arriving together with data_ok still kills the fetch
        discard_eff_s = discard_r | inst_flush_s;
    end

    // Next-state logic
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s = ST_ADDR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    state_nx_s = ST_DATA;
                end else if (inst_flush_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok && discard_eff_s) begin
                    state_nx_s = ST_IDLE;
                end else if (bus_data_ok) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, latched bus fields and registered port outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_DATA;
            last_owner_r <= OWN_DATA;
            discard_r    <= 1'b0;
            bus_req      <= 1'b0;
            bus_wr       <= 1'b0;
            bus_size     <= 2'd0;
            bus_addr     <= {ADDR_WIDTH{1'b0}};
            bus_wdata    <= {DATA_WIDTH{1'b0}};
            inst_rdata   <= {DATA_WIDTH{1'b0}};
            inst_ready   <= 1'b0;
            data_rdata   <= {DATA_WIDTH{1'b0}};
            data_ready   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r   <= grant_inst_s;
                        discard_r <= 1'b0;
                        bus_req   <= 1'b1;
                        if (grant_inst_s) begin
                            bus_addr  <= inst_addr;
                            bus_wr    <= 1'b0;
                            bus_size  <= 2'd2;
                            bus_wdata <= {DATA_WIDTH{1'b0}};
                        end else begin
                            bus_addr  <= data_addr;
                            bus_wr    <= data_wr;
                            bus_size  <= data_size;
                            bus_wdata <= data_wdata;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        if (inst_flush_s) begin
                            discard_r <= 1'b1;
                        end
                    end else if (inst_flush_s) begin
                        bus_req <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok) begin
                        last_owner_r <= owner_r;
                        discard_r    <= 1'b0;
                        if (!discard_eff_s) begin
                            if (owner_r == OWN_INST) begin
                                inst_ready <= 1'b1;
                                inst_rdata <= bus_rdata;
                            end else begin
                                data_ready <= 1'b1;
                                data_rdata <= bus_rdata;
                            end
                        end
                    end else if (inst_flush_s) begin
                        discard_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    discard_r <= 1'b0;
                end
                default: begin
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_req = (data_req & ~data_ready) | (inst_req & ~inst_ready & ~flush);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Reference model: one pending transaction record plus expected port values
    bit          txn_valid = 1'b0, txn_inst = 1'b0, txn_addr_acc = 1'b0, txn_killed = 1'b0;
    bit          deliver = 1'b0, last_served_inst = 1'b0;
    bit          e_bus_req = 1'b0, e_bus_wr = 1'b0, e_inst_ready = 1'b0, e_data_ready = 1'b0;
    logic [1:0]  e_bus_size = 2'd0;
    logic [31:0] e_bus_addr = 32'd0, e_bus_wdata = 32'd0, e_inst_rdata = 32'd0, e_data_rdata = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pick_inst, inst_ok;
        if (!rst) begin
            txn_valid = 1'b0; txn_addr_acc = 1'b0; txn_killed = 1'b0; deliver = 1'b0;
            last_served_inst = 1'b0;
            e_bus_req = 1'b0; e_bus_wr = 1'b0; e_bus_size = 2'd0; e_bus_addr = 32'd0;
            e_bus_wdata = 32'd0; e_inst_ready = 1'b0; e_data_ready = 1'b0;
            e_inst_rdata = 32'd0; e_data_rdata = 32'd0;
        end else begin
            e_inst_ready = 1'b0;
            e_data_ready = 1'b0;
            inst_ok = inst_req && !flush;
            if (deliver) begin
                deliver = 1'b0;
            end else if (!txn_valid) begin
                if (inst_ok || data_req) begin
                    pick_inst = (inst_ok && data_req) ? !last_served_inst : inst_ok;
                    txn_valid = 1'b1; txn_inst = pick_inst; txn_addr_acc = 1'b0; txn_killed = 1'b0;
                    e_bus_req = 1'b1;
                    e_bus_addr = pick_inst ? inst_addr : data_addr;
                    e_bus_wr = pick_inst ? 1'b0 : data_wr;
                    e_bus_size = pick_inst ? 2'd2 : data_size;
                    e_bus_wdata = data_wdata;
                end
            end else if (!txn_addr_acc) begin
                if (bus_addr_ok) begin
                    txn_addr_acc = 1'b1; e_bus_req = 1'b0; txn_killed = txn_inst && flush;
                end else if (txn_inst && flush) begin
                    txn_valid = 1'b0; e_bus_req = 1'b0;
                end
            end else begin
                if (txn_inst && flush) txn_killed = 1'b1;
                if (bus_data_ok) begin
                    last_served_inst = txn_inst;
                    txn_valid = 1'b0;
                    if (!txn_killed) begin
                        deliver = 1'b1;
                        if (txn_inst) begin e_inst_ready = 1'b1; e_inst_rdata = bus_rdata; end
                        else begin e_data_ready = 1'b1; e_data_rdata = bus_rdata; end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("bus_req", bus_req, e_bus_req);
        if (e_bus_req) begin
            chk("bus_addr", bus_addr, e_bus_addr);
            chk("bus_wr", bus_wr, e_bus_wr);
            chk("bus_size", bus_size, e_bus_size);
            if (e_bus_wr) chk("bus_wdata", bus_wdata, e_bus_wdata);
        end
        chk("inst_ready", inst_ready, e_inst_ready);
        chk("data_ready", data_ready, e_data_ready);
        chk("inst_rdata", inst_rdata, e_inst_rdata);
        chk("data_rdata", data_rdata, e_data_rdata);
    endtask

    // One clock: check combinational stall on the settled inputs, advance, check registers
    task automatic cycle();
        #2;
        chk("stall_req", stall_req,
            (data_req && !e_data_ready) || (inst_req && !e_inst_ready && !flush));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic bus_auto();
        bus_addr_ok = txn_valid && !txn_addr_acc;
        bus_data_ok = txn_valid && txn_addr_acc;
        bus_rdata = $urandom();
    endtask

    task automatic drive_random();
        if (e_inst_ready || flush || !inst_req) begin
            inst_req = ($urandom_range(99) < 50);
            inst_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (e_data_ready || !data_req) begin
            data_req = ($urandom_range(99) < 35);
            data_wr = 1'($urandom_range(1));
            data_size = 2'($urandom_range(2));
            data_addr = $urandom();
            data_wdata = $urandom();
        end
        flush = ($urandom_range(99) < 8);
        rst = ($urandom_range(199) != 0);
        bus_addr_ok = (txn_valid && !txn_addr_acc) ? ($urandom_range(99) < 60) : 1'b0;
        bus_data_ok = (txn_valid && txn_addr_acc) ? ($urandom_range(99) < 45)
                                                  : ($urandom_range(99) < 10);
        bus_rdata = $urandom();
    endtask

    initial begin
        bit order[4];
        int n;

        // reset state: every output low
        do_reset();
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_size", bus_size, 2'd0);
        chk("rst_readys", {inst_ready, data_ready}, 2'b00);
        chk("rst_rdatas", {inst_rdata, data_rdata}, 64'd0);

        // minimum-latency load
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
        cycle();
        chk("t1_bus_req_c1", bus_req, 1'b1);
        chk("t1_bus_addr_c1", bus_addr, 32'h8000_1000);
        bus_addr_ok = 1'b1;
        cycle();
        chk("t1_ready_c2", data_ready, 1'b0);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("t1_ready_c3", data_ready, 1'b1);
        chk("t1_rdata_c3", data_rdata, 32'hDEAD_BEEF);
        data_req = 1'b0; bus_data_ok = 1'b0;
        cycle();
        chk("t1_ready_c4", data_ready, 1'b0);
        chk("t1_rdata_hold", data_rdata, 32'hDEAD_BEEF);

        // both ports held: strict alternation starting with fetch
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            bus_auto();
            cycle();
            if (inst_ready || data_ready) begin
                order[n] = inst_ready;
                n++;
                inst_addr = inst_addr + 32'd4;
            end
        end
        chk("t2_pulses", n, 4);
        chk("t2_order", {order[0], order[1], order[2], order[3]}, 4'b1010);

        // fetch cancelled in the address phase
        do_reset();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        cycle();
        chk("t3_bus_req_c1", bus_req, 1'b1);
        chk("t3_bus_addr_c1", bus_addr, 32'hBFC0_0000);
        chk("t3_bus_size_c1", bus_size, 2'd2);
        chk("t3_bus_wr_c1", bus_wr, 1'b0);
        cycle();
        flush = 1'b1;
        cycle();
        chk("t3_bus_req_c3", bus_req, 1'b0);
        chk("t3_ready_c3", inst_ready, 1'b0);
        inst_req = 1'b0; flush = 1'b0;
        cycle();
        chk("t3_ready_c4", inst_ready, 1'b0);

        // fetch flushed in the data phase, data arrives later and is dropped
        do_reset();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        cycle();
        bus_addr_ok = 1'b1;
        cycle();
        bus_addr_ok = 1'b0; flush = 1'b1; inst_req = 1'b0;
        cycle();
        flush = 1'b0;
        cycle();
        bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
        cycle();
        chk("t4_no_ready", inst_ready, 1'b0);
        chk("t4_rdata_kept", inst_rdata, 32'd0);
        bus_data_ok = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0200;
        cycle();
        chk("t4_regrant", bus_req, 1'b1);
        chk("t4_regrant_addr", bus_addr, 32'h0000_0200);

        // byte store completes despite flush
        do_reset();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0003;
        data_wdata = 32'h0000_00AB;
        cycle();
        chk("t5_bus_wr", bus_wr, 1'b1);
        chk("t5_bus_size", bus_size, 2'd0);
        chk("t5_bus_addr", bus_addr, 32'h0000_0003);
        chk("t5_bus_wdata", bus_wdata, 32'h0000_00AB);
        bus_addr_ok = 1'b1;
        cycle();
        bus_addr_ok = 1'b0; flush = 1'b1; bus_data_ok = 1'b1;
        cycle();
        chk("t5_ready", data_ready, 1'b1);
        flush = 1'b0; bus_data_ok = 1'b0; data_req = 1'b0;
        cycle();

        // reset in the data phase, then a stray data_ok
        do_reset();
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0100;
        cycle();
        bus_addr_ok = 1'b1;
        cycle();
        bus_addr_ok = 1'b0; rst = 1'b0;
        cycle();
        chk("t6_bus_req", bus_req, 1'b0);
        chk("t6_ready", data_ready, 1'b0);
        rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        chk("t6_stall", stall_req, 1'b1);
        cycle();
        chk("t6_no_ready", data_ready, 1'b0);
        chk("t6_regrant", bus_req, 1'b1);
        bus_data_ok = 1'b0;

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
